// File: rtl/capture_sequencer.sv
// capture_sequencer
// Sequences one scope frame at a time: arm, holdoff, wait for a level/slope
// trigger (or an auto-mode timeout), write DEPTH decimated samples into the
// sample RAM, then hold the frame for the display reader until it acks.
// Everything runs on the ADC clock; frame_ack arrives already synchronized.

module capture_sequencer #(
    parameter int DATA_W  = 14,
    parameter int DEPTH   = 160,
    parameter int ADDR_W  = 8,
    parameter int HOLDOFF = 4,
    parameter int AUTO_TO = 65535
) (
    input  logic              clk_adc,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic              slope,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [7:0]        decim,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              frame_ack,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_ready,
    output logic              auto_trig,
    output logic              armed
);

    localparam int HOLD_W = $clog2(HOLDOFF + 1);
    localparam int TO_W   = $clog2(AUTO_TO + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(AUTO_TO - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    // A one-sample frame is complete as soon as the trigger write is issued
    localparam bit ONE_DEEP = (DEPTH == 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t              state_r;
    state_t              next_state_s;

    logic [DATA_W-1:0]   s1_r;
    logic                ge1_r;
    logic                ge2_r;
    logic                enable_r;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic [TO_W-1:0]     to_cnt_r;
    logic [7:0]          dec_cnt_r;
    logic [7:0]          dec_lat_r;

    logic                wr_en_r;
    logic [ADDR_W-1:0]   wr_addr_r;
    logic [DATA_W-1:0]   wr_data_r;
    logic                frame_ready_r;
    logic                auto_trig_r;
    logic                armed_r;

    logic                trig_s;
    logic                mode_single_s;
    logic                mode_auto_s;
    logic                start_cap_s;
    logic                force_s;
    logic                cap_write_s;
    logic [ADDR_W-1:0]   next_addr_s;

    // Threshold crossing: ge1 and ge2 are the compare results of the two most
    // recent samples, so trig lines up with the sample held in s1.
    assign trig_s        = slope ? (~ge1_r & ge2_r) : (ge1_r & ~ge2_r);
    assign mode_single_s = (mode == 2'b10);
    assign mode_auto_s   = (mode == 2'b01);
    assign next_addr_s   = wr_addr_r + ADDR_ONE;

    // Next-state and per-cycle write/trigger decisions
    always_comb begin
        next_state_s = state_r;
        start_cap_s  = 1'b0;
        force_s      = 1'b0;
        cap_write_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (mode_single_s) begin
                    if (enable && !enable_r) begin
                        next_state_s = ST_ARM;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end else if (enable) begin
                    next_state_s = ST_ARM;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (!enable) begin
                    next_state_s = ST_IDLE;
                end else if (hold_cnt_r == HOLD_LAST) begin
                    next_state_s = ST_WAIT;
                end else begin
                    next_state_s = ST_ARM;
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    next_state_s = ST_IDLE;
                end else if (trig_s) begin
                    start_cap_s  = 1'b1;
                    next_state_s = ONE_DEEP ? ST_DONE : ST_CAPTURE;
                end else if (mode_auto_s && (to_cnt_r == TO_LAST)) begin
                    start_cap_s  = 1'b1;
                    force_s      = 1'b1;
                    next_state_s = ONE_DEEP ? ST_DONE : ST_CAPTURE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_CAPTURE: begin
                if (!enable) begin
                    next_state_s = ST_IDLE;
                end else if (dec_cnt_r == 8'd0) begin
                    cap_write_s = 1'b1;
                    if (next_addr_s == ADDR_LAST) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_CAPTURE;
                    end
                end else begin
                    next_state_s = ST_CAPTURE;
                end
            end
            ST_DONE: begin
                // Only an ack against a presented frame releases DONE
                if (frame_ready_r && frame_ack) begin
                    if (mode_single_s || !enable) begin
                        next_state_s = ST_IDLE;
                    end else begin
                        next_state_s = ST_ARM;
                    end
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register, front-end pipeline and phase counters
    always_ff @(posedge clk_adc) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            s1_r       <= {DATA_W{1'b0}};
            ge1_r      <= 1'b0;
            ge2_r      <= 1'b0;
            enable_r   <= 1'b0;
            hold_cnt_r <= {HOLD_W{1'b0}};
            to_cnt_r   <= {TO_W{1'b0}};
            dec_cnt_r  <= 8'd0;
            dec_lat_r  <= 8'd0;
        end else begin
            state_r  <= next_state_s;
            s1_r     <= adc_data;
            ge1_r    <= (adc_data >= trig_level);
            ge2_r    <= ge1_r;
            enable_r <= enable;

            if ((state_r == ST_ARM) && (next_state_s == ST_ARM)) begin
                hold_cnt_r <= hold_cnt_r + 1'b1;
            end else begin
                hold_cnt_r <= {HOLD_W{1'b0}};
            end

            // Saturate so a mode switch into auto mid-wait cannot wrap
            if ((state_r == ST_WAIT) && (next_state_s == ST_WAIT)) begin
                if (to_cnt_r != TO_LAST) begin
                    to_cnt_r <= to_cnt_r + 1'b1;
                end
            end else begin
                to_cnt_r <= {TO_W{1'b0}};
            end

            // decim is sampled once per frame, at the trigger
            if (start_cap_s) begin
                dec_lat_r <= decim;
                dec_cnt_r <= decim;
            end else if (state_r == ST_CAPTURE) begin
                if (dec_cnt_r == 8'd0) begin
                    dec_cnt_r <= dec_lat_r;
                end else begin
                    dec_cnt_r <= dec_cnt_r - 8'd1;
                end
            end
        end
    end

    // Registered RAM write port and status outputs
    always_ff @(posedge clk_adc) begin
        if (reset) begin
            wr_en_r       <= 1'b0;
            wr_addr_r     <= {ADDR_W{1'b0}};
            wr_data_r     <= {DATA_W{1'b0}};
            frame_ready_r <= 1'b0;
            auto_trig_r   <= 1'b0;
            armed_r       <= 1'b0;
        end else begin
            wr_en_r <= start_cap_s | cap_write_s;
            if (start_cap_s) begin
                wr_addr_r <= {ADDR_W{1'b0}};
                wr_data_r <= s1_r;
            end else if (cap_write_s) begin
                wr_addr_r <= next_addr_s;
                wr_data_r <= s1_r;
            end

            frame_ready_r <= (state_r == ST_DONE) && !(frame_ready_r && frame_ack);

            if (force_s) begin
                auto_trig_r <= 1'b1;
            end else if ((next_state_s == ST_ARM) && (state_r != ST_ARM)) begin
                auto_trig_r <= 1'b0;
            end

            armed_r <= (next_state_s == ST_ARM) || (next_state_s == ST_WAIT);
        end
    end

    assign wr_en       = wr_en_r;
    assign wr_addr     = wr_addr_r;
    assign wr_data     = wr_data_r;
    assign frame_ready = frame_ready_r;
    assign auto_trig   = auto_trig_r;
    assign armed       = armed_r;

endmodule

// File: tb/tb_capture_sequencer.sv
// Scoreboard bench for capture_sequencer: stimulus pushes the expected RAM
// writes into a queue, and a negedge monitor pops and compares every wr_en.

module tb_capture_sequencer;

    localparam int DATA_W  = 14;
    localparam int DEPTH   = 160;
    localparam int ADDR_W  = 8;
    localparam int HOLDOFF = 4;
    localparam int AUTO_TO = 100;

    logic              clk_adc    = 1'b0;
    logic              reset      = 1'b1;
    logic              enable     = 1'b0;
    logic [1:0]        mode       = 2'b00;
    logic              slope      = 1'b0;
    logic [DATA_W-1:0] trig_level = 14'd8192;
    logic [7:0]        decim      = 8'd0;
    logic [DATA_W-1:0] adc_data   = 14'd0;
    logic              frame_ack  = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              frame_ready;
    logic              auto_trig;
    logic              armed;

    typedef struct {
        int addr;
        int data;
        int gap;      // required cycles since previous write, 0 = any
        int abs_cyc;  // required cycle number, -1 = any
    } exp_t;

    exp_t exp_q[$];
    int   compared    = 0;
    int   mismatched  = 0;
    int   cyc         = 0;
    int   exp_ready   = 0;
    int   last_wr_cyc = 0;
    int   last_wr_addr = 0;
    int   pattern     = 1;   // 0 ramp, 1 constant, 2 square
    int   const_val   = 0;
    int   phase       = 0;
    logic fr_prev     = 1'b0;

    capture_sequencer #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
        .HOLDOFF(HOLDOFF), .AUTO_TO(AUTO_TO)
    ) dut (
        .clk_adc(clk_adc), .reset(reset), .enable(enable), .mode(mode),
        .slope(slope), .trig_level(trig_level), .decim(decim),
        .adc_data(adc_data), .frame_ack(frame_ack), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .frame_ready(frame_ready),
        .auto_trig(auto_trig), .armed(armed)
    );

    initial forever #5 clk_adc = ~clk_adc;

    always @(posedge clk_adc) cyc <= cyc + 1;

    // ADC sample generator
    initial forever begin
        @(posedge clk_adc);
        #1;
        case (pattern)
            0:       adc_data = DATA_W'((phase * 64) % 16384);
            2:       adc_data = ((phase % 8) < 4) ? 14'd12000 : 14'd2000;
            default: adc_data = DATA_W'(const_val);
        endcase
        phase++;
    end

    task automatic check(input string name, input int got, input int want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("FAIL %s got=%0d want=%0d (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic int exp_data(input int kind, input int i, input int cval);
        case (kind)
            0:       return (8192 + 64 * i) % 16384;
            2:       return ((i % 8) < 4) ? 2000 : 12000;
            default: return cval;
        endcase
    endfunction

    task automatic push_frame(input int kind, input int cval, input int n,
                              input int gap, input int first_abs);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.addr    = i;
            e.data    = exp_data(kind, i, cval);
            e.gap     = (i == 0) ? 0 : gap;
            e.abs_cyc = (i == 0) ? first_abs : -1;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every write and every frame_ready rise must be expected
    always @(negedge clk_adc) begin
        exp_t e;
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", int'(wr_addr), -1);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", int'(wr_addr), e.addr);
                check("wr_data", int'(wr_data), e.data);
                if (e.gap > 0)      check("wr_gap", cyc - last_wr_cyc, e.gap);
                if (e.abs_cyc >= 0) check("wr_first_cycle", cyc, e.abs_cyc);
            end
            last_wr_cyc  = cyc;
            last_wr_addr = int'(wr_addr);
        end
        if ((frame_ready === 1'b1) && (fr_prev == 1'b0)) begin
            if (exp_ready == 0) begin
                check("unexpected_frame_ready", 1, 0);
            end else begin
                exp_ready--;
                check("ready_after_last_write", cyc - last_wr_cyc, 1);
                check("ready_last_addr", last_wr_addr, DEPTH - 1);
            end
        end
        fr_prev = (frame_ready === 1'b1);
    end

    task automatic wait_ready(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_adc);
            if (frame_ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check(name, 0, 1);
    endtask

    task automatic wait_armed(output int a_cyc);
        bit seen = 1'b0;
        a_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_adc);
            if (armed) begin
                seen  = 1'b1;
                a_cyc = cyc;
                break;
            end
        end
        if (!seen) check("armed_timeout", 0, 1);
    endtask

    task automatic wait_write(input int addr);
        bit seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_adc);
            if (wr_en && (int'(wr_addr) == addr)) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("write_timeout", 0, 1);
    endtask

    task automatic do_ack();
        @(posedge clk_adc); #1 frame_ack = 1'b1;
        @(posedge clk_adc); #1 frame_ack = 1'b0;
        @(negedge clk_adc);
        check("ready_clear_after_ack", int'(frame_ready), 0);
    endtask

    task automatic quiet_check(input string name, input int cycles);
        int armed_cnt = 0;
        int ready_cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_adc);
            if (armed)       armed_cnt++;
            if (frame_ready) ready_cnt++;
        end
        check({name, "_armed_cycles"}, armed_cnt, 0);
        check({name, "_ready_cycles"}, ready_cnt, 0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_wr_en"},       int'(wr_en), 0);
        check({name, "_wr_addr"},     int'(wr_addr), 0);
        check({name, "_wr_data"},     int'(wr_data), 0);
        check({name, "_frame_ready"}, int'(frame_ready), 0);
        check({name, "_auto_trig"},   int'(auto_trig), 0);
        check({name, "_armed"},       int'(armed), 0);
    endtask

    initial begin
        int a;
        repeat (3) @(posedge clk_adc);
        @(negedge clk_adc);
        check_outputs_zero("reset");
        @(posedge clk_adc); #1 reset = 1'b0;

        // T1: normal, rising, ramp, decim 0, two back-to-back frames
        pattern = 0; mode = 2'b00; slope = 1'b0; decim = 8'd0;
        push_frame(0, 0, DEPTH, 1, -1); exp_ready++;
        enable = 1'b1;
        wait_ready("t1_f1_ready_timeout", 1000);
        check("t1_f1_queue_left", exp_q.size(), 0);
        check("t1_auto_trig", int'(auto_trig), 0);
        push_frame(0, 0, DEPTH, 1, -1); exp_ready++;
        do_ack();
        wait_ready("t1_f2_ready_timeout", 1000);
        check("t1_f2_queue_left", exp_q.size(), 0);
        enable = 1'b0;
        do_ack();

        // T2: decim 3, single step trigger; decim/level changed mid-frame
        pattern = 1; const_val = 0; decim = 8'd3;
        push_frame(1, 10000, DEPTH, 4, -1); exp_ready++;
        enable = 1'b1;
        wait_armed(a);
        repeat (10) @(posedge clk_adc);
        #1 const_val = 10000;
        repeat (20) @(posedge clk_adc);
        #1 decim = 8'd0; trig_level = 14'd16000;
        wait_ready("t2_ready_timeout", 1500);
        check("t2_queue_left", exp_q.size(), 0);
        enable = 1'b0; trig_level = 14'd8192;
        do_ack();

        // T3: auto mode with flat input, forced trigger after AUTO_TO
        mode = 2'b01; const_val = 0; decim = 8'd0;
        enable = 1'b1;
        wait_armed(a);
        push_frame(1, 0, DEPTH, 1, a + HOLDOFF + AUTO_TO); exp_ready++;
        wait_ready("t3_ready_timeout", 600);
        check("t3_queue_left", exp_q.size(), 0);
        check("t3_auto_trig", int'(auto_trig), 1);
        enable = 1'b0;
        do_ack();

        // T4: single mode; no re-arm while enable stays high
        mode = 2'b10; pattern = 0;
        push_frame(0, 0, DEPTH, 1, -1); exp_ready++;
        enable = 1'b1;
        wait_ready("t4_f1_ready_timeout", 1000);
        check("t4_f1_queue_left", exp_q.size(), 0);
        check("t4_auto_trig_cleared", int'(auto_trig), 0);
        do_ack();
        quiet_check("t4_single_hold", 1000);
        enable = 1'b0;
        repeat (2) @(posedge clk_adc);
        push_frame(0, 0, DEPTH, 1, -1); exp_ready++;
        #1 enable = 1'b1;
        wait_ready("t4_f2_ready_timeout", 1000);
        check("t4_f2_queue_left", exp_q.size(), 0);
        enable = 1'b0;
        do_ack();

        // T5: falling slope on a square wave, stray ack while armed
        mode = 2'b00; slope = 1'b1; pattern = 2;
        push_frame(2, 0, DEPTH, 1, -1); exp_ready++;
        enable = 1'b1;
        wait_armed(a);
        @(posedge clk_adc); #1 frame_ack = 1'b1;
        @(posedge clk_adc); #1 frame_ack = 1'b0;
        wait_ready("t5_ready_timeout", 1000);
        check("t5_queue_left", exp_q.size(), 0);
        enable = 1'b0;
        do_ack();
        slope = 1'b0;

        // T6: enable dropped at write 50 aborts the frame
        pattern = 0;
        push_frame(0, 0, 51, 1, -1);
        enable = 1'b1;
        wait_write(50);
        enable = 1'b0;
        @(negedge clk_adc);
        check("t6_wr_en_after_abort", int'(wr_en), 0);
        quiet_check("t6_after_abort", 300);
        check("t6_queue_left", exp_q.size(), 0);

        // T7: reset during capture clears every output next cycle
        push_frame(0, 0, 21, 1, -1);
        enable = 1'b1;
        wait_write(20);
        reset = 1'b1; enable = 1'b0;
        @(negedge clk_adc);
        check_outputs_zero("t7_mid_reset");
        @(posedge clk_adc); #1 reset = 1'b0;
        check("t7_queue_left", exp_q.size(), 0);
        repeat (5) @(negedge clk_adc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
